// File: rtl/uart_pkg.sv
// Constants and helpers shared by the UART receive and transmit FIFOs.
package uart_pkg;

    localparam int unsigned UART_PAYLOAD_BITS         = 8;
    localparam int unsigned UART_FIFO_DEPTH           = 16;
    localparam int unsigned UART_FIFO_ALMOST_FULL_LVL = 12;

    // Each FIFO entry carries the payload plus a one-bit BREAK flag.
    function automatic int unsigned fifo_entry_width(input int unsigned payload_bits);
        return payload_bits + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side strobe and consumer-side valid/ready handshake of the RX FIFO.
interface uart_rx_fifo_if #(
    parameter int unsigned PAYLOAD_BITS = 8
);

    logic                    in_valid;
    logic [PAYLOAD_BITS-1:0] in_data;
    logic                    in_break;
    logic                    out_valid;
    logic                    out_ready;
    logic [PAYLOAD_BITS-1:0] out_data;
    logic                    out_break;

    modport master (
        output in_valid, in_data, in_break, out_ready,
        input  out_valid, out_data, out_break
    );

    modport slave (
        input  in_valid, in_data, in_break, out_ready,
        output out_valid, out_data, out_break
    );

endinterface

// File: rtl/uart_fifo_ram.sv
// FIFO storage: register array with a synchronous write port and an asynchronous read port.
module uart_fifo_ram #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with sticky overrun flag; the receiver cannot be stalled.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS    = UART_PAYLOAD_BITS,
    parameter int unsigned DEPTH           = UART_FIFO_DEPTH,
    parameter int unsigned ALMOST_FULL_LVL = UART_FIFO_ALMOST_FULL_LVL,
    localparam int unsigned AW             = $clog2(DEPTH),
    localparam int unsigned LW             = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    uart_rx_fifo_if.slave rx,
    output logic [LW-1:0] level,
    output logic          almost_full,
    output logic          overflow,
    input  logic          clear_overflow,
    input  logic          flush
);

    localparam int unsigned EW          = fifo_entry_width(PAYLOAD_BITS);
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL    = LW'(ALMOST_FULL_LVL);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          overflow_q;
    logic [EW-1:0] rd_entry;
    logic          full;
    logic          non_empty;
    logic          push;
    logic          pop;
    logic          drop;

    assign full      = (level_q == FULL_LVL);
    assign non_empty = (level_q != '0);
    assign pop       = non_empty && rx.out_ready && !flush;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push      = rx.in_valid && !flush && (!full || pop);
    assign drop      = rx.in_valid && !flush && full && !pop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      level_q <= level_q + 1'b1;
                else if (pop && !push) level_q <= level_q - 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    uart_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push && resetn),
        .wr_addr (wr_ptr),
        .wr_data ({rx.in_break, rx.in_data}),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    assign rx.out_valid = non_empty;
    assign rx.out_data  = non_empty ? rd_entry[PAYLOAD_BITS-1:0] : '0;
    assign rx.out_break = non_empty && rd_entry[PAYLOAD_BITS];
    assign level        = level_q;
    assign almost_full  = (level_q >= AF_LVL);
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] level;
    logic       almost_full;
    logic       overflow;
    logic       clear_overflow;
    logic       flush;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    uart_rx_fifo_if #(.PAYLOAD_BITS(8)) rx_if ();

    uart_rx_fifo #(
        .PAYLOAD_BITS    (8),
        .DEPTH           (16),
        .ALMOST_FULL_LVL (12)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .rx             (rx_if),
        .level          (level),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic b);
        rx_if.in_valid = 1'b1;
        rx_if.in_data  = d;
        rx_if.in_break = b;
        tick();
        rx_if.in_valid = 1'b0;
        rx_if.in_data  = '0;
        rx_if.in_break = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic b);
        expect_eq({tag, "_valid"}, 32'(rx_if.out_valid), 32'd1);
        expect_eq({tag, "_data"},  32'(rx_if.out_data), 32'(d));
        expect_eq({tag, "_break"}, 32'(rx_if.out_break), 32'(b));
        rx_if.out_ready = 1'b1;
        tick();
        rx_if.out_ready = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        clear_overflow = 1'b0;
        flush = 1'b0;
        rx_if.in_valid = 1'b0;
        rx_if.in_data = '0;
        rx_if.in_break = 1'b0;
        rx_if.out_ready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        expect_eq("rst_level", 32'(level), 32'd0);
        expect_eq("rst_valid", 32'(rx_if.out_valid), 32'd0);
        expect_eq("rst_af", 32'(almost_full), 32'd0);
        expect_eq("rst_ovf", 32'(overflow), 32'd0);
        expect_eq("rst_data", 32'(rx_if.out_data), 32'd0);
        expect_eq("rst_break", 32'(rx_if.out_break), 32'd0);

        // Basic order and one-cycle latency.
        push(8'h41, 1'b0);
        expect_eq("lat_valid", 32'(rx_if.out_valid), 32'd1);
        expect_eq("lat_data", 32'(rx_if.out_data), 32'h41);
        push(8'h42, 1'b0);
        push(8'h43, 1'b0);
        expect_eq("lvl3", 32'(level), 32'd3);
        pop_check("p41", 8'h41, 1'b0);
        pop_check("p42", 8'h42, 1'b0);
        pop_check("p43", 8'h43, 1'b0);
        expect_eq("empty_lvl", 32'(level), 32'd0);
        expect_eq("empty_valid", 32'(rx_if.out_valid), 32'd0);
        expect_eq("empty_data", 32'(rx_if.out_data), 32'd0);

        // Overrun drops the word and sets the sticky flag.
        fill16();
        expect_eq("full_lvl", 32'(level), 32'd16);
        expect_eq("full_af", 32'(almost_full), 32'd1);
        expect_eq("full_ovf0", 32'(overflow), 32'd0);
        push(8'hAA, 1'b0);
        expect_eq("ovr_ovf", 32'(overflow), 32'd1);
        expect_eq("ovr_lvl", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) pop_check("drain", 8'(i), 1'b0);
        expect_eq("drain_lvl", 32'(level), 32'd0);
        expect_eq("drain_valid", 32'(rx_if.out_valid), 32'd0);
        expect_eq("ovf_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        expect_eq("ovf_clr", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop.
        fill16();
        rx_if.in_valid = 1'b1;
        rx_if.in_data = 8'h55;
        pop_check("fp00", 8'h00, 1'b0);
        rx_if.in_valid = 1'b0;
        rx_if.in_data = '0;
        expect_eq("fp_ovf", 32'(overflow), 32'd0);
        expect_eq("fp_lvl", 32'(level), 32'd16);
        for (int i = 1; i < 16; i++) pop_check("fp_drain", 8'(i), 1'b0);
        pop_check("fp55", 8'h55, 1'b0);
        expect_eq("fp_empty", 32'(level), 32'd0);

        // BREAK ordering.
        push(8'h10, 1'b0);
        push(8'h00, 1'b1);
        push(8'h20, 1'b0);
        pop_check("b10", 8'h10, 1'b0);
        pop_check("brk", 8'h00, 1'b1);
        pop_check("b20", 8'h20, 1'b0);

        // almost_full threshold.
        for (int i = 0; i < 12; i++) push(8'(8'h80 + i), 1'b0);
        expect_eq("af12", 32'(almost_full), 32'd1);
        expect_eq("lvl12", 32'(level), 32'd12);
        push(8'hEE, 1'b0);
        pop_check("af_pop", 8'h80, 1'b0);
        expect_eq("af_stay", 32'(almost_full), 32'd1);
        pop_check("af_pop2", 8'h81, 1'b0);
        expect_eq("af11", 32'(almost_full), 32'd0);
        expect_eq("lvl11", 32'(level), 32'd11);

        // Flush with an in_valid while full must not count as overrun.
        for (int i = 0; i < 5; i++) push(8'hC0, 1'b0);
        expect_eq("pre_flush_lvl", 32'(level), 32'd16);
        flush = 1'b1;
        rx_if.in_valid = 1'b1;
        rx_if.in_data = 8'h99;
        tick();
        flush = 1'b0;
        rx_if.in_valid = 1'b0;
        expect_eq("flush_lvl", 32'(level), 32'd0);
        expect_eq("flush_valid", 32'(rx_if.out_valid), 32'd0);
        expect_eq("flush_ovf", 32'(overflow), 32'd0);

        // Set and clear in the same cycle leave overflow set; flush keeps it.
        fill16();
        clear_overflow = 1'b1;
        push(8'hBB, 1'b0);
        clear_overflow = 1'b0;
        expect_eq("setclr_ovf", 32'(overflow), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_eq("flush_keep_ovf", 32'(overflow), 32'd1);
        expect_eq("flush2_lvl", 32'(level), 32'd0);

        // Reset mid-operation with a receiver pulse during reset.
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1'b0);
        expect_eq("pre_rst_lvl", 32'(level), 32'd5);
        resetn = 1'b0;
        rx_if.in_valid = 1'b1;
        rx_if.in_data = 8'hDD;
        tick();
        resetn = 1'b1;
        rx_if.in_valid = 1'b0;
        expect_eq("mrst_lvl", 32'(level), 32'd0);
        expect_eq("mrst_valid", 32'(rx_if.out_valid), 32'd0);
        expect_eq("mrst_ovf", 32'(overflow), 32'd0);
        push(8'h77, 1'b0);
        expect_eq("post_rst_lvl", 32'(level), 32'd1);
        pop_check("p77", 8'h77, 1'b0);
        expect_eq("final_empty", 32'(rx_if.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
